// File: rtl/conv_pool_stage_pkg.sv
// Shared definitions for the convolution pooling stage.
// Holds the derived geometry functions (conv output edge, pooled edge, samples per
// image), the stream FSM state encoding and a signed max helper.
package conv_pool_stage_pkg;

  // Widest sample the max helper supports; callers sign-extend into it.
  localparam int unsigned MaxWidth = 32;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

  function automatic int unsigned calc_conv_out(input int unsigned image_size,
                                                input int unsigned kernel_size);
    return image_size - kernel_size + 1;
  endfunction

  function automatic int unsigned calc_pool_out(input int unsigned image_size,
                                                input int unsigned kernel_size);
    return calc_conv_out(image_size, kernel_size) / 2;
  endfunction

  function automatic int unsigned calc_samples(input int unsigned image_size);
    return image_size * image_size;
  endfunction

  function automatic logic signed [MaxWidth-1:0] smax(input logic signed [MaxWidth-1:0] a,
                                                      input logic signed [MaxWidth-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/conv_pool_stage_line_buffer.sv
// pool_line_buffer: one row of horizontal pair maxima awaiting the odd conv row.
// Ports:
//   clk_i    clock
//   we_i     write enable (synchronous)
//   addr_i   entry index (cc>>1), shared by write and read
//   wdata_i  pair maximum to store
//   rdata_o  combinational read of entry addr_i
// Contents are never cleared; every entry is written on an even conv row before the
// odd row reads it.
module pool_line_buffer #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 12,
  localparam int unsigned AddrW    = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrW-1:0]     addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_pool_stage.sv
// conv_pool_stage: tracks the image position of the raw convolution stream, drops
// samples whose window overhangs the image edge, optionally applies ReLU, and performs
// 2x2 stride-2 max pooling.
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   start        pulse marking the cycle conv_result carries image pixel 0
//   conv_result  signed convolution sample, one per cycle
//   out_data     signed pooled value
//   out_valid    one-cycle qualifier for out_data
//   out_last     high with the final pooled value of an image
//   busy         high while an image stream is being consumed
// Build option: define CONV_POOL_RELU_EN to clamp negative samples to 0 before pooling.
// DATA_WIDTH must not exceed 32.
module conv_pool_stage
  import conv_pool_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned IMAGE_SIZE  = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] conv_result,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy
);

  localparam int unsigned ConvOut = calc_conv_out(IMAGE_SIZE, KERNEL_SIZE);
  localparam int unsigned PoolOut = calc_pool_out(IMAGE_SIZE, KERNEL_SIZE);
  localparam int unsigned CntW    = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int unsigned AddrW   = (PoolOut > 1) ? $clog2(PoolOut) : 1;

  state_e state_q, state_d;
  logic [CntW-1:0] row_q, row_d, col_q, col_d;
  logic active;

  logic [CntW-1:0] cr, cc;
  logic sample_ok;
  logic signed [DATA_WIDTH-1:0] sample_v, h_q, pair, pooled;
  logic [DATA_WIDTH-1:0] lb_rdata;
  logic lb_we, emit, emit_last;

  logic signed [DATA_WIDTH-1:0] out_data_q;
  logic out_valid_q, out_last_q;

  // Sample 0 is consumed in the IDLE cycle that sees start, so the counters already
  // sit at (0,0) there and advance exactly as they do in STREAM.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    active  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          active  = 1'b1;
          state_d = StStream;
        end
      end
      StStream: active = 1'b1;
      default: state_d = StIdle;
    endcase
    if (reset) begin
      active = 1'b0;
    end
    if (active) begin
      if (col_q == CntW'(IMAGE_SIZE - 1)) begin
        col_d = '0;
        if (row_q == CntW'(IMAGE_SIZE - 1)) begin
          row_d   = '0;
          state_d = StIdle;
        end else begin
          row_d = row_q + CntW'(1);
        end
      end else begin
        col_d = col_q + CntW'(1);
      end
    end
  end

  always_comb begin
    sample_ok = active && (row_q >= CntW'(KERNEL_SIZE - 1)) && (col_q >= CntW'(KERNEL_SIZE - 1));
    cr        = row_q - CntW'(KERNEL_SIZE - 1);
    cc        = col_q - CntW'(KERNEL_SIZE - 1);
    sample_v  = signed'(conv_result);
`ifdef CONV_POOL_RELU_EN
    if (sample_v < 0) begin
      sample_v = '0;
    end
`endif
    pair      = DATA_WIDTH'(smax(MaxWidth'(h_q), MaxWidth'(sample_v)));
    pooled    = DATA_WIDTH'(smax(MaxWidth'(signed'(lb_rdata)), MaxWidth'(pair)));
    lb_we     = sample_ok && cc[0] && !cr[0];
    emit      = sample_ok && cc[0] && cr[0];
    emit_last = (cr == CntW'(ConvOut - 1)) && (cc == CntW'(ConvOut - 1));
  end

  pool_line_buffer #(
    .DataWidth(DATA_WIDTH),
    .Depth    (PoolOut)
  ) u_line_buffer (
    .clk_i  (clk),
    .we_i   (lb_we),
    .addr_i (AddrW'(cc >> 1)),
    .wdata_i(pair),
    .rdata_o(lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= emit;
      out_last_q  <= emit && emit_last;
      if (emit) begin
        out_data_q <= pooled;
      end
    end
  end

  // Left-of-pair hold register; intentionally not reset, always written before use.
  always_ff @(posedge clk) begin
    if (sample_ok && !cc[0]) begin
      h_q <= sample_v;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = active;

endmodule

// File: tb/tb_conv_pool_stage.sv
module tb_conv_pool_stage;

  localparam int DW = 16;
  localparam int K  = 5;
  localparam int N  = 28;
  localparam int CO = N - K + 1;
  localparam int PO = CO / 2;
  localparam int NS = N * N;

  logic clk = 1'b0;
  logic reset, start;
  logic [DW-1:0] conv_result;
  logic [DW-1:0] out_data;
  logic out_valid, out_last, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_pool_stage #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(K),
    .IMAGE_SIZE (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .conv_result(conv_result),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .busy       (busy)
  );

  // Monitor: sole writer of the observation logs; tests remember a base index.
  int mon_cyc[$];
  logic signed [DW-1:0] mon_data[$];
  logic mon_last[$];
  int busy_cyc[$];
  int nz_cyc[$];
  int stray_last[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      mon_cyc.push_back(cyc);
      mon_data.push_back(signed'(out_data));
      mon_last.push_back(out_last);
    end else if (out_last !== 1'b0) begin
      stray_last.push_back(cyc);
    end
    if (busy === 1'b1) busy_cyc.push_back(cyc);
    if (out_data !== '0) nz_cyc.push_back(cyc);
  end

  // Reference model: images as arrays, pooling computed from geometry alone.
  logic signed [DW-1:0] img [2][NS];
  int exp_cyc[$];
  logic signed [DW-1:0] exp_data[$];
  logic exp_last[$];

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef CONV_POOL_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic fill_image(input int id, input int mode);
    for (int i = 0; i < NS; i++) begin
      case (mode)
        0: img[id][i] = DW'(i);
        1: img[id][i] = -16'sd100;
        2: img[id][i] = -16'sd3;
        default: img[id][i] = DW'($urandom);
      endcase
    end
    if (mode == 1) begin
      img[id][4*N+4] = -16'sd5;
      img[id][4*N+5] = 16'sd7;
      img[id][5*N+4] = -16'sd1;
      img[id][5*N+5] = 16'sd3;
    end
  endtask

  // Appends expected outputs of image id started at cycle s0, up to cycle limit.
  task automatic model_image(input int id, input int s0, input int limit);
    logic signed [DW-1:0] m, v;
    int c;
    for (int pr = 0; pr < PO; pr++) begin
      for (int pc = 0; pc < PO; pc++) begin
        m = relu(img[id][(2*pr+K-1)*N + 2*pc+K-1]);
        for (int d = 1; d < 4; d++) begin
          v = relu(img[id][(2*pr+(d/2)+K-1)*N + 2*pc+(d%2)+K-1]);
          if (v > m) m = v;
        end
        c = s0 + (2*pr+K)*N + (2*pc+K) + 1;
        if (c <= limit) begin
          exp_cyc.push_back(c);
          exp_data.push_back(m);
          exp_last.push_back(pr == PO-1 && pc == PO-1);
        end
      end
    end
  endtask

  task automatic drive_image(input int id, input int spur, input int rst_at, output int s0);
    s0 = 0;
    for (int i = 0; i < NS; i++) begin
      @(posedge clk); #1;
      if (i == 0) s0 = cyc;
      start       = (i == 0) || (i == spur);
      reset       = (i == rst_at);
      conv_result = img[id][i];
    end
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start       = 1'b0;
      reset       = 1'b0;
      conv_result = DW'($urandom);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; conv_result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b last=%b data=%0h busy=%b, want 0 0 0 0",
               out_valid, out_last, out_data, busy);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_stream(input int mode, input int spur, input string name);
    int s0, mb, bb, nb;
    fill_image(0, mode);
    mb = mon_cyc.size();
    bb = busy_cyc.size();
    drive_image(0, spur, -1, s0);
    drive_idle(4);
    exp_cyc.delete(); exp_data.delete(); exp_last.delete();
    model_image(0, s0, 1 << 30);
    n_checks++;
    if (mon_cyc.size() - mb != exp_cyc.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d outputs, want %0d", name, mon_cyc.size() - mb,
               exp_cyc.size());
    end
    for (int k = 0; k < exp_cyc.size() && mb + k < mon_cyc.size(); k++) begin
      n_checks++;
      if (mon_cyc[mb+k] != exp_cyc[k] || mon_data[mb+k] !== exp_data[k] ||
          mon_last[mb+k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL %s out%0d: got start+%0d data %0d last %b, want start+%0d data %0d last %b",
                 name, k, mon_cyc[mb+k] - s0, mon_data[mb+k], mon_last[mb+k],
                 exp_cyc[k] - s0, exp_data[k], exp_last[k]);
      end
    end
    nb = busy_cyc.size() - bb;
    n_checks++;
    if (nb != NS || busy_cyc[bb] != s0 || busy_cyc[busy_cyc.size()-1] != s0 + NS - 1) begin
      n_fail++;
      $display("FAIL %s busy: got %0d cycles, want %0d cycles from start to start+%0d",
               name, nb, NS, NS - 1);
    end
  endtask

  task automatic test_mid_reset();
    int s0, s1, mb, bad;
    fill_image(0, 3);
    fill_image(1, 0);
    mb = mon_cyc.size();
    drive_image(0, -1, 300, s0);
    drive_idle(6);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: got valid=%b last=%b data=%0h busy=%b, want 0 0 0 0",
               out_valid, out_last, out_data, busy);
    end
    drive_image(1, -1, -1, s1);
    drive_idle(4);
    exp_cyc.delete(); exp_data.delete(); exp_last.delete();
    model_image(0, s0, s0 + 300);
    model_image(1, s1, 1 << 30);
    n_checks++;
    if (mon_cyc.size() - mb != exp_cyc.size()) begin
      n_fail++;
      $display("FAIL midreset count: got %0d outputs, want %0d", mon_cyc.size() - mb,
               exp_cyc.size());
    end
    for (int k = 0; k < exp_cyc.size() && mb + k < mon_cyc.size(); k++) begin
      n_checks++;
      if (mon_cyc[mb+k] != exp_cyc[k] || mon_data[mb+k] !== exp_data[k] ||
          mon_last[mb+k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL midreset out%0d: got cyc %0d data %0d last %b, want cyc %0d data %0d last %b",
                 k, mon_cyc[mb+k], mon_data[mb+k], mon_last[mb+k], exp_cyc[k], exp_data[k],
                 exp_last[k]);
      end
    end
    bad = 0;
    foreach (nz_cyc[i]) if (nz_cyc[i] > s0 + 300 && nz_cyc[i] < s1) bad++;
    foreach (busy_cyc[i]) if (busy_cyc[i] > s0 + 300 && busy_cyc[i] < s1) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midreset quiet: got %0d nonzero/busy cycles between reset and restart, want 0",
               bad);
    end
  endtask

  task automatic test_back_to_back();
    int s0, s1, mb, bb, nlast, nbusy;
    fill_image(0, 3);
    fill_image(1, 0);
    mb = mon_cyc.size();
    bb = busy_cyc.size();
    drive_image(0, -1, -1, s0);
    drive_image(1, -1, -1, s1);
    drive_idle(4);
    exp_cyc.delete(); exp_data.delete(); exp_last.delete();
    model_image(0, s0, 1 << 30);
    model_image(1, s1, 1 << 30);
    n_checks++;
    if (mon_cyc.size() - mb != 2 * PO * PO) begin
      n_fail++;
      $display("FAIL b2b count: got %0d outputs, want %0d", mon_cyc.size() - mb, 2 * PO * PO);
    end
    nlast = 0;
    for (int k = 0; k < exp_cyc.size() && mb + k < mon_cyc.size(); k++) begin
      if (mon_last[mb+k] === 1'b1) nlast++;
      n_checks++;
      if (mon_cyc[mb+k] != exp_cyc[k] || mon_data[mb+k] !== exp_data[k] ||
          mon_last[mb+k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL b2b out%0d: got cyc %0d data %0d last %b, want cyc %0d data %0d last %b",
                 k, mon_cyc[mb+k], mon_data[mb+k], mon_last[mb+k], exp_cyc[k], exp_data[k],
                 exp_last[k]);
      end
    end
    n_checks++;
    if (nlast != 2) begin
      n_fail++;
      $display("FAIL b2b last_pulses: got %0d, want 2", nlast);
    end
    nbusy = 0;
    for (int i = bb; i < busy_cyc.size(); i++)
      if (busy_cyc[i] >= s0 && busy_cyc[i] < s0 + 2 * NS) nbusy++;
    n_checks++;
    if (nbusy != 2 * NS || busy_cyc.size() - bb != 2 * NS) begin
      n_fail++;
      $display("FAIL b2b busy: got %0d in-window of %0d total, want %0d continuous", nbusy,
               busy_cyc.size() - bb, 2 * NS);
    end
  endtask

  initial begin
    test_reset();
    test_stream(0, -1, "ramp");
    test_stream(1, -1, "mixed");
    test_stream(2, -1, "all_neg3");
    test_stream(3, -1, "random");
    test_stream(0, 50, "spurious_start");
    test_mid_reset();
    test_back_to_back();
    n_checks++;
    if (stray_last.size() != 0) begin
      n_fail++;
      $display("FAIL stray_last: got %0d out_last cycles without out_valid, want 0",
               stray_last.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_pool_stage.md
# conv_pool_stage

Downstream stage of the convolution datapath. Consumes the raw per-cycle convolution result stream and tracks the image position of every sample. It discards samples whose window overhangs the image edge and applies an optional ReLU. It performs 2×2 stride-2 max pooling, emitting one pooled value per 2×2 block of valid convolution outputs, ready for the next layer's buffer.

## Interface
- `DATA_WIDTH`, 16: sample width, signed fixed-point; format passed through unchanged.
- `KERNEL_SIZE`, 5: convolution kernel edge.
- `IMAGE_SIZE`, 28: input image edge. `IMAGE_SIZE-KERNEL_SIZE+1` must be even.
- `clk`  in  1: clock.
- `reset`  in  1: reset; one clock, synchronous, active-high.
- `start`  in  1: pulse. Asserted in the cycle `conv_result` carries the window for image pixel 0, i.e. one cycle after pixel 0 is driven on the datapath's pixel input.
- `conv_result`  in  DATA_WIDTH: signed adder-tree output, one sample per cycle, no gaps.
- `out_data`  out  DATA_WIDTH: signed pooled value.
- `out_valid`  out  1: one-cycle pulse qualifying `out_data`.
- `out_last`  out  1: high with the final pooled value of an image.
- `busy`  out  1: high while an image stream is being consumed.

## Operation
- Derived constants:
  - `CONV_OUT = IMAGE_SIZE-KERNEL_SIZE+1`
  - `POOL_OUT = CONV_OUT/2`
  - `SAMPLES = IMAGE_SIZE**2`
- States:
  - IDLE: `start` moves to STREAM, with sample 0 consumed in that same cycle.
  - STREAM: consumes one sample per cycle using `row`/`col` counters, 0..IMAGE_SIZE-1. `col` wraps to 0 and increments `row`. After sample `SAMPLES-1` the block returns to IDLE.
- Sample (row,col) is valid iff `row>=KERNEL_SIZE-1` and `col>=KERNEL_SIZE-1`. Conv coordinates are `cr=row-(KERNEL_SIZE-1)` and `cc=col-(KERNEL_SIZE-1)`. Invalid samples are dropped with no side effect.
- Every comparison is a signed compare. Ties have no observable effect.
- For each valid sample v:
  - Even `cc`: hold v in `h_reg`.
  - Odd `cc`: compute `pair = max(h_reg, v)`.
    - Even `cr`: write `pair` to `line_buf[cc>>1]`.
    - Odd `cr`: register `max(line_buf[cc>>1], pair)` into `out_data` and pulse `out_valid`.
- `out_last` is high with the pooled output for conv (CONV_OUT-1, CONV_OUT-1).
- `start` while in STREAM is ignored and does not restart the count.
- `start` in the cycle STREAM returns to IDLE (the cycle after sample `SAMPLES-1`) is accepted, so back-to-back images run gap-free.
- `line_buf` and `h_reg` are not cleared between images. Each entry is always written before it is read.

## Timing
- Reset values: `out_data=0`, `out_valid=0`, `out_last=0`, `busy=0`, state IDLE, counters 0.
- Reset in mid-stream aborts the image. No further `out_valid` is produced until the next `start`.
- `busy` is high in cycles start..start+SAMPLES-1.
- Latency is one cycle, from the odd-row/odd-col conv sample to `out_valid`.
- With defaults:
  - First `out_valid` is at cycle start+146 (sample index 145 = image (5,5)).
  - Last `out_valid`, with `out_last`, is at start+784.
  - The image produces 144 outputs in total.
- The last `out_valid` may coincide with the first cycle of the next image's STREAM. Both operate independently.

## Configuration
- `CONV_POOL_RELU_EN`:
  - Defined: each valid sample is clamped before pooling (negative→0). Outputs are therefore ≥0.
  - Undefined: raw signed values are pooled.

## Structure
- The shared package holds:
  - the `CONV_OUT`, `POOL_OUT` and `SAMPLES` derivation functions;
  - the state encoding (IDLE, STREAM);
  - a signed `max` function.
- Sub-module `pool_line_buffer`: POOL_OUT×DATA_WIDTH register array with one synchronous write port and one combinational read port, both addressed by `cc>>1`.

## Test plan
- Ramp: `conv_result` = sample index, defaults. Require 144 outputs; first `out_data=145` at start+146; last `out_data=783` with `out_last` at start+784.
- Mixed signs: first 2×2 conv block (image (4,4),(4,5),(5,4),(5,5)) = {-5,7,-1,3}, all else -100.
  - Require first output 7.
  - Without ReLU, other outputs are -100. With `CONV_POOL_RELU_EN`, they are 0.
- All samples -3: 144 outputs of -3 without ReLU; 144 outputs of 0 with `CONV_POOL_RELU_EN`.
- Reset pulse at start+300: require no `out_valid` afterwards, `busy=0`, and all outputs 0 until a new `start`. A new image then yields a correct 144-output ramp.
- Spurious `start` at start+50: require unchanged counts and timing versus the ramp test.
- Back-to-back images with `start` at cycle S and S+784: require 288 outputs, two `out_last` pulses, and `busy` continuous.
